vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator. It succeeds the fixed 640x480@60 controller and sits between the pixel source (frame buffer or pattern generator) and the DAC/pins. It adds configurable timing and sync polarity, a pixel-request lead for sources with fixed latency, a frame-boundary start/stop control, and frame/line strobes. All outputs are registered except the request bus, which is decoded directly from the counter registers.

---
 rtl/vga_timing_gen.sv | 160 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync/blank timing, pixel request
// bus with a configurable lead, and frame-boundary start/stop control.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_W   = 16,
  parameter int LEAD     = 1,
  parameter int CNT_W    = 12
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_req,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start,
  output logic              line_start,
  output logic              busy
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_START + V_ACTIVE);

  // One extra bit so h_cnt+LEAD cannot wrap near the end of a line.
  localparam logic [CNT_W:0] RQ_START = (CNT_W+1)'(H_START);
  localparam logic [CNT_W:0] RQ_END   = (CNT_W+1)'(H_START + H_ACTIVE);
  localparam logic [CNT_W:0] LEAD_C   = (CNT_W+1)'(LEAD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t            state_reg;
  logic              busy_reg;
  logic [CNT_W-1:0]  h_cnt_reg;
  logic [CNT_W-1:0]  v_cnt_reg;
  logic [CNT_W-1:0]  h_cnt_next;
  logic [CNT_W-1:0]  v_cnt_next;
  logic              h_last;
  logic              v_last;
  logic              frame_end;
  logic              running;
  logic              h_act;
  logic              v_act;
  logic              active;
  logic [CNT_W:0]    h_lead;
  logic              req;

  assign h_last    = (h_cnt_reg == H_LAST);
  assign v_last    = (v_cnt_reg == V_LAST);
  assign frame_end = h_last && v_last;
  assign running   = busy_reg;

  always_comb begin
    h_cnt_next = h_cnt_reg + 1'b1;
    v_cnt_next = v_cnt_reg;
    if (h_last) begin
      h_cnt_next = '0;
      v_cnt_next = v_last ? '0 : v_cnt_reg + 1'b1;
    end
  end

  // en=1 on the final position of a stopping frame keeps the raster running.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          h_cnt_reg <= '0;
          v_cnt_reg <= '0;
          if (en) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          h_cnt_reg <= h_cnt_next;
          v_cnt_reg <= v_cnt_next;
          if (!en) state_reg <= STOP;
        end
        STOP: begin
          h_cnt_reg <= h_cnt_next;
          v_cnt_reg <= v_cnt_next;
          if (en) begin
            state_reg <= RUN;
          end else if (frame_end) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          h_cnt_reg <= '0;
          v_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign h_act  = (h_cnt_reg >= H_START_C) && (h_cnt_reg < H_END_C);
  assign v_act  = (v_cnt_reg >= V_START_C) && (v_cnt_reg < V_END_C);
  assign active = running && h_act && v_act;

  assign h_lead  = {1'b0, h_cnt_reg} + LEAD_C;
  assign req     = running && (h_lead >= RQ_START) && (h_lead < RQ_END) && v_act;
  assign pix_req = req;
  assign pix_x   = req ? CNT_W'(h_lead - RQ_START) : '0;
  assign pix_y   = req ? (v_cnt_reg - V_START_C) : '0;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      hsync       <= (running && (h_cnt_reg < H_SYNC_C)) ? HS_POL : ~HS_POL;
      vsync       <= (running && (v_cnt_reg < V_SYNC_C)) ? VS_POL : ~VS_POL;
      de          <= active;
      rgb         <= active ? pix_data : '0;
      line_start  <= running && (h_cnt_reg == '0);
      frame_start <= running && (h_cnt_reg == '0) && (v_cnt_reg == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 20x10 raster with LEAD=3
// and mixed sync polarity (hsync active-low, vsync active-high).
module tb_vga_timing_gen;

  localparam int HS = 4, HB = 4, HA = 8, HF = 4;
  localparam int VS = 2, VB = 2, VA = 4, VF = 2;
  localparam int HT = HS + HB + HA + HF;   // 20
  localparam int VT = VS + VB + VA + VF;   // 10
  localparam int HST = HS + HB;            // 8
  localparam int VST = VS + VB;            // 4
  localparam int FR = HT * VT;             // 200
  localparam int LD = 3;
  localparam int CW = 8;
  localparam int DW = 16;

  logic          vga_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] pix_data;
  logic          pix_req;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [DW-1:0] rgb;
  logic          frame_start;
  logic          line_start;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(1'b0), .VS_POL(1'b1),
    .DATA_W(DW), .LEAD(LD), .CNT_W(CW)
  ) dut (
    .vga_clk(vga_clk),
    .sys_rst(sys_rst),
    .en(en),
    .pix_data(pix_data),
    .pix_req(pix_req),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .rgb(rgb),
    .frame_start(frame_start),
    .line_start(line_start),
    .busy(busy)
  );

  // Pixel source with fixed 3-clock latency; returns junk when not requested.
  logic [DW-1:0] src_d1, src_d2, src_d3;
  always @(posedge vga_clk) begin
    src_d1 <= pix_req ? {pix_y, pix_x} : 16'hBEEF;
    src_d2 <= src_d1;
    src_d3 <= src_d2;
  end
  assign pix_data = src_d3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int p, h, v, q, rh, rv, e_x, e_y;
  logic e_act, e_req;
  logic [DW-1:0] e_rgb;
  int mm_hs, mm_vs, mm_de, mm_rgb, mm_ls, mm_fs, mm_req;
  int n_hs, n_vs, n_de, n_fs, n_ls, n_req, n_busy;
  int first_req, first_de, last_de, busy_fall, gap, busy_low, req_wait;
  logic [CW-1:0] fx, fy;
  logic [DW-1:0] first_rgb, last_rgb;

  task automatic check_reset_values(input string pfx);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_hsync"}, 32'(hsync), 1);
    check({pfx, "_vsync"}, 32'(vsync), 0);
    check({pfx, "_de"}, 32'(de), 0);
    check({pfx, "_rgb"}, 32'(rgb), 0);
    check({pfx, "_frame_start"}, 32'(frame_start), 0);
    check({pfx, "_line_start"}, 32'(line_start), 0);
    check({pfx, "_pix_req"}, 32'(pix_req), 0);
    check({pfx, "_pix_x"}, 32'(pix_x), 0);
    check({pfx, "_pix_y"}, 32'(pix_y), 0);
  endtask

  initial begin
    mm_hs = 0; mm_vs = 0; mm_de = 0; mm_rgb = 0; mm_ls = 0; mm_fs = 0; mm_req = 0;
    n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0; n_ls = 0; n_req = 0; n_busy = 0;
    first_req = -1; first_de = -1; last_de = -1; busy_fall = -1;
    fx = '0; fy = '0; first_rgb = '0; last_rgb = '0;

    // Reset values while held in reset
    repeat (2) @(negedge vga_clk);
    check_reset_values("reset");

    // Released, en=0: stays idle
    sys_rst = 1'b0;
    repeat (3) @(negedge vga_clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_hsync", 32'(hsync), 1);
    check("idle_vsync", 32'(vsync), 0);
    check("idle_frame_start", 32'(frame_start), 0);

    // Start: busy one clock after en, frame_start one clock after that
    en = 1'b1;
    @(negedge vga_clk);
    check("start_busy", 32'(busy), 1);
    check("start_fs_early", 32'(frame_start), 0);
    check("start_req_pos0", 32'(pix_req), 0);

    // Full frame: registered outputs at step j reflect position j-1,
    // the request bus reflects position j.
    for (int j = 1; j <= FR; j++) begin
      @(negedge vga_clk);
      p = j - 1; h = p % HT; v = p / HT;
      e_act = (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
      e_rgb = e_act ? {8'(v - VST), 8'(h - HST)} : 16'h0000;
      if (hsync !== ((h < HS) ? 1'b0 : 1'b1)) mm_hs++;
      if (vsync !== ((v < VS) ? 1'b1 : 1'b0)) mm_vs++;
      if (de !== e_act) mm_de++;
      if (rgb !== e_rgb) mm_rgb++;
      if (line_start !== (h == 0)) mm_ls++;
      if (frame_start !== (p == 0)) mm_fs++;
      if (hsync == 1'b0) n_hs++;
      if (vsync == 1'b1) n_vs++;
      if (de) n_de++;
      if (frame_start) n_fs++;
      if (line_start) n_ls++;
      if (de) begin
        if (first_de < 0) begin first_de = p; first_rgb = rgb; end
        last_de = p; last_rgb = rgb;
      end
      q = j % FR; rh = q % HT; rv = q / HT;
      e_req = (rh + LD >= HST) && (rh + LD < HST + HA) && (rv >= VST) && (rv < VST + VA);
      e_x = e_req ? rh + LD - HST : 0;
      e_y = e_req ? rv - VST : 0;
      if (pix_req !== e_req || pix_x !== 8'(e_x) || pix_y !== 8'(e_y)) mm_req++;
      if (pix_req) n_req++;
      if (pix_req && first_req < 0) begin first_req = j; fx = pix_x; fy = pix_y; end
    end
    check("hsync_active_clocks", 32'(n_hs), HS * VT);
    check("vsync_active_clocks", 32'(n_vs), VS * HT);
    check("de_high_clocks", 32'(n_de), HA * VA);
    check("frame_start_count", 32'(n_fs), 1);
    check("line_start_count", 32'(n_ls), VT);
    check("pix_req_count", 32'(n_req), HA * VA);
    check("hsync_pattern", 32'(mm_hs), 0);
    check("vsync_pattern", 32'(mm_vs), 0);
    check("de_pattern", 32'(mm_de), 0);
    check("rgb_pattern", 32'(mm_rgb), 0);
    check("line_start_pattern", 32'(mm_ls), 0);
    check("frame_start_pattern", 32'(mm_fs), 0);
    check("req_bus_pattern", 32'(mm_req), 0);
    check("first_req_pos", 32'(first_req), 85);
    check("first_req_x", 32'(fx), 0);
    check("first_req_y", 32'(fy), 0);
    check("first_de_pos", 32'(first_de), 88);
    check("first_rgb", 32'(first_rgb), 32'h0000);
    check("last_de_pos", 32'(last_de), 155);
    check("last_rgb", 32'(last_rgb), 32'h0307);

    // en dropped mid-frame: frame completes, then idle without a new frame_start
    for (int j = FR + 1; j <= 2 * FR + 20; j++) begin
      @(negedge vga_clk);
      if (j == 300) en = 1'b0;
      if (frame_start) n_fs++;
      if (busy) n_busy++;
      if (!busy && busy_fall < 0) busy_fall = j;
    end
    check("stop_frame_start_total", 32'(n_fs), 2);
    check("stop_busy_fall", 32'(busy_fall), 2 * FR);
    check("stop_busy_clocks", 32'(n_busy), FR - 1);
    check("stop_hsync_idle", 32'(hsync), 1);
    check("stop_vsync_idle", 32'(vsync), 0);
    check("stop_de", 32'(de), 0);
    check("stop_rgb", 32'(rgb), 0);
    check("stop_line_start", 32'(line_start), 0);
    check("stop_pix_req", 32'(pix_req), 0);

    // Restart, then drop and re-raise en inside the frame: no gap
    en = 1'b1;
    @(negedge vga_clk);
    check("restart_busy", 32'(busy), 1);
    check("restart_fs_early", 32'(frame_start), 0);
    @(negedge vga_clk);
    check("restart_frame_start", 32'(frame_start), 1);
    gap = 0; busy_low = 0;
    for (int k = 1; k <= 2 * FR; k++) begin
      @(negedge vga_clk);
      if (k == 49) en = 1'b0;
      if (k == 149) en = 1'b1;
      if (!busy) busy_low++;
      if (frame_start) begin
        gap = k;
        break;
      end
    end
    check("reraise_frame_period", 32'(gap), FR);
    check("reraise_busy_low", 32'(busy_low), 0);

    // Move to (v=5, h=11), then pulse reset asynchronously
    repeat (110) @(negedge vga_clk);
    check("pre_rst_de", 32'(de), 1);
    check("pre_rst_rgb", 32'(rgb), 32'h0102);
    check("pre_rst_req", 32'(pix_req), 1);
    check("pre_rst_x", 32'(pix_x), 6);
    check("pre_rst_y", 32'(pix_y), 1);
    #2 sys_rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge vga_clk);
    sys_rst = 1'b0;
    @(negedge vga_clk);
    check("post_rst_busy", 32'(busy), 1);
    check("post_rst_fs_early", 32'(frame_start), 0);
    @(negedge vga_clk);
    check("post_rst_frame_start", 32'(frame_start), 1);
    check("post_rst_line_start", 32'(line_start), 1);
    check("post_rst_hsync", 32'(hsync), 0);
    check("post_rst_vsync", 32'(vsync), 1);
    req_wait = 0;
    for (int k = 1; k <= FR; k++) begin
      @(negedge vga_clk);
      if (pix_req) begin
        req_wait = k;
        break;
      end
    end
    check("post_rst_first_req_wait", 32'(req_wait), 84);
    check("post_rst_first_req_x", 32'(pix_x), 0);
    check("post_rst_first_req_y", 32'(pix_y), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
